result_window_stats: RTL



---
 rtl/result_window_stats_if.sv | 62 ++++++
 rtl/result_window_stats.sv | 154 +++++++++++++++
 2 files changed

// File: rtl/result_window_stats_if.sv
// ---------------------------------------------------------------------------
// result_window_stats_if
//
// Bundles the sample input handshake and the summary-record output handshake
// of result_window_stats.
//
//   master : upstream producer / downstream consumer side (drives samples,
//            flush and out_ready; observes in_ready and the record)
//   slave  : the window statistics block itself
//
// Signals
//   in_valid, in_result[DATA_W], in_gt_zero, flush  -> sample stream
//   in_ready                                        <- block can accept
//   out_valid, out_sum[SUM_W], out_max[DATA_W],
//   out_pos_count[CNT_W], out_count[CNT_W]          <- summary record
//   out_ready                                       -> consumer takes record
//   out_max_run[CNT_W]                              <- only with RUN_LEN_EN
// ---------------------------------------------------------------------------
interface result_window_stats_if #(
  parameter int DATA_W = 5,
  parameter int SUM_W  = 8,
  parameter int CNT_W  = 4
);

  logic              in_valid;
  logic [DATA_W-1:0] in_result;
  logic              in_gt_zero;
  logic              flush;
  logic              in_ready;
  logic              out_valid;
  logic              out_ready;
  logic [SUM_W-1:0]  out_sum;
  logic [DATA_W-1:0] out_max;
  logic [CNT_W-1:0]  out_pos_count;
  logic [CNT_W-1:0]  out_count;
`ifdef RUN_LEN_EN
  logic [CNT_W-1:0]  out_max_run;

  modport master (
    output in_valid, in_result, in_gt_zero, flush, out_ready,
    input  in_ready, out_valid, out_sum, out_max, out_pos_count, out_count,
           out_max_run
  );

  modport slave (
    input  in_valid, in_result, in_gt_zero, flush, out_ready,
    output in_ready, out_valid, out_sum, out_max, out_pos_count, out_count,
           out_max_run
  );
`else
  modport master (
    output in_valid, in_result, in_gt_zero, flush, out_ready,
    input  in_ready, out_valid, out_sum, out_max, out_pos_count, out_count
  );

  modport slave (
    input  in_valid, in_result, in_gt_zero, flush, out_ready,
    output in_ready, out_valid, out_sum, out_max, out_pos_count, out_count
  );
`endif

endinterface : result_window_stats_if

// File: rtl/result_window_stats.sv
// ---------------------------------------------------------------------------
// result_window_stats
//
// Collects result/gt_zero samples into windows of WIN_LEN samples (or fewer
// when flush closes a partial window) and emits one summary record per
// window: sum, unsigned max, count of gt_zero samples and sample count.
// The record is held on a valid/ready handshake until the consumer takes it;
// no samples are accepted while a record is pending.
//
// Ports
//   clk    : rising-edge clock
//   reset  : synchronous, active-high reset
//   bus    : result_window_stats_if.slave (sample in / record out)
//
// Optional feature (macro RUN_LEN_EN)
//   Adds out_max_run: longest run of consecutive accepted samples with
//   in_gt_zero=1 within the window. Idle cycles do not break a run.
// ---------------------------------------------------------------------------
module result_window_stats #(
  parameter int DATA_W  = 5,
  parameter int WIN_LEN = 8,
  parameter int SUM_W   = 8,
  parameter int CNT_W   = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  result_window_stats_if.slave  bus
);

  typedef enum logic {
    ACCUM  = 1'b0,
    REPORT = 1'b1
  } state_t;

  state_t state, state_nxt;

  // Running window totals
  logic [SUM_W-1:0]  sum_acc, sum_nxt;
  logic [DATA_W-1:0] max_acc, max_nxt;
  logic [CNT_W-1:0]  pos_acc, pos_nxt;
  logic [CNT_W-1:0]  cnt_acc, cnt_nxt;
`ifdef RUN_LEN_EN
  logic [CNT_W-1:0]  run_cur, run_cur_nxt;
  logic [CNT_W-1:0]  run_max, run_max_nxt;
`endif

  logic accept;       // sample handshake completes this cycle
  logic close_win;    // window closes this cycle, record latched
  logic take_rec;     // consumer takes the pending record

  // Readiness is derived from the registered state only, so the accept and
  // close terms never loop back through the handshake outputs.
  assign bus.in_ready  = (state == ACCUM);
  assign bus.out_valid = (state == REPORT);

  assign accept    = bus.in_valid && (state == ACCUM);
  assign take_rec  = (state == REPORT) && bus.out_ready;
  // A flush with nothing collected and nothing arriving is ignored.
  assign close_win = (state == ACCUM) &&
                     ((accept && (cnt_nxt == CNT_W'(WIN_LEN))) ||
                      (bus.flush && ((cnt_acc != '0) || accept)));

  // Totals including the sample accepted this cycle, so a closing window
  // reports the sample that closed it.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves
    // it unassigned and no latch is inferred.
    sum_nxt = sum_acc;
    max_nxt = max_acc;
    pos_nxt = pos_acc;
    cnt_nxt = cnt_acc;
`ifdef RUN_LEN_EN
    run_cur_nxt = run_cur;
`endif
    if (accept) begin
      sum_nxt = sum_acc + SUM_W'(bus.in_result);
      max_nxt = (bus.in_result > max_acc) ? bus.in_result : max_acc;
      pos_nxt = pos_acc + CNT_W'(bus.in_gt_zero);
      cnt_nxt = cnt_acc + CNT_W'(1);
`ifdef RUN_LEN_EN
      run_cur_nxt = bus.in_gt_zero ? (run_cur + CNT_W'(1)) : '0;
`endif
    end
`ifdef RUN_LEN_EN
    run_max_nxt = (run_cur_nxt > run_max) ? run_cur_nxt : run_max;
`endif
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    unique case (state)
      ACCUM:   if (close_win) state_nxt = REPORT;
      REPORT:  if (take_rec)  state_nxt = ACCUM;
      default: state_nxt = ACCUM;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= ACCUM;
    end else begin
      state <= state_nxt;
    end
  end

  // Accumulators: updated on accept, cleared once the record is taken.
  always_ff @(posedge clk) begin
    if (reset || take_rec) begin
      sum_acc <= '0;
      max_acc <= '0;
      pos_acc <= '0;
      cnt_acc <= '0;
`ifdef RUN_LEN_EN
      run_cur <= '0;
      run_max <= '0;
`endif
    end else if (accept) begin
      sum_acc <= sum_nxt;
      max_acc <= max_nxt;
      pos_acc <= pos_nxt;
      cnt_acc <= cnt_nxt;
`ifdef RUN_LEN_EN
      run_cur <= run_cur_nxt;
      run_max <= run_max_nxt;
`endif
    end
  end

  // Record registers: loaded only when a window closes, so they stay stable
  // while the record waits and keep their values after it is taken.
  always_ff @(posedge clk) begin
    if (reset) begin
      bus.out_sum       <= '0;
      bus.out_max       <= '0;
      bus.out_pos_count <= '0;
      bus.out_count     <= '0;
`ifdef RUN_LEN_EN
      bus.out_max_run   <= '0;
`endif
    end else if (close_win) begin
      bus.out_sum       <= sum_nxt;
      bus.out_max       <= max_nxt;
      bus.out_pos_count <= pos_nxt;
      bus.out_count     <= cnt_nxt;
`ifdef RUN_LEN_EN
      bus.out_max_run   <= run_max_nxt;
`endif
    end
  end

endmodule : result_window_stats
